ascon_perm_engine: RTL and testbench
====================================

ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1, number of Ascon rounds applied per clock; legal values 1,2,3,4,6,12, any other value a elaboration error.
REQ-002 SHALL have parameter MAX_ROUNDS, default 12, upper bound on requested rounds; fixed at 12 for Ascon, other values an elaboration error.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  engine accepts request this cycle.
REQ-007 SHALL have port rounds  input  4  permutation rounds requested, sampled on accept.
REQ-008 SHALL have port state_in  input  320  initial state {x4,x3,x2,x1,x0}, x0 in bits [63:0].
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port state_out  output  320  permuted state, same word order as state_in.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DONE; in_ready = (FSM==IDLE).
REQ-014 SHALL accept on in_valid&&in_ready: capture state_in, set n = min(rounds,12), round index i = 12-n, go RUN if n>0 else DONE.
REQ-015 SHALL in RUN apply k = min(UNROLL, remaining) rounds per cycle; unrolled stages beyond k bypassed; i advances by k, remaining decreases by k.
REQ-016 SHALL use round constant for index i: ((15-i)<<4)|i XORed into x2 low byte, then Ascon 5-bit S-box, then linear layer (x0:19,28; x1:61,39; x2:1,6; x3:10,17; x4:7,41).
REQ-017 SHALL enter DONE when remaining reaches 0; out_valid high exactly in DONE; latency accept-to-out_valid = ceil(n/UNROLL) cycles, 1 cycle for n=0.
REQ-018 SHALL hold state_out stable while out_valid && !out_ready.
REQ-019 SHALL on out_valid&&out_ready return to IDLE next cycle; no new accept in that same cycle.
REQ-020 SHALL treat rounds=0 as identity (state_out = state_in) and rounds 13..15 as 12.
REQ-021 SHALL drive state_out from the state register in all FSM states.

Reset
REQ-022 SHALL on rst asynchronously force FSM=IDLE, state register=0, remaining=0, i=0.
REQ-023 SHALL give reset output values in_ready=1, out_valid=0, busy=0, state_out=0.
REQ-024 SHALL on rst mid-RUN or mid-DONE discard the operation with no out_valid pulse.

Configuration
REQ-025 SHALL, when ASCON_PERM_ABORT_EN is defined, add port abort input 1; abort in RUN or DONE forces IDLE next cycle, out_valid low, state register cleared to 0.
REQ-026 SHALL, with ASCON_PERM_ABORT_EN defined, drive in_ready = (FSM==IDLE)&&!abort, so abort wins over a simultaneous request.
REQ-027 SHALL, without ASCON_PERM_ABORT_EN, have no abort port; every accepted request completes.

Structure
REQ-028 SHALL place in package ascon_pkg: ascon_state_t (5 x 64-bit words), ROUND_CONST function/table for indices 0..11, MAX_ROUNDS constant.
REQ-029 SHALL instantiate UNROLL copies of combinational sub-module ascon_round (inputs state, round index, enable; output state; enable=0 passes through).

Verification
REQ-030 SHALL check UNROLL=1, state_in=0, rounds=12 -> out_valid 12 cycles after accept, state_out equal to golden software model of p^12.
REQ-031 SHALL check UNROLL=4, rounds=6 -> out_valid after 2 cycles (4+2 rounds), state_out equal to UNROLL=1 result for same input.
REQ-032 SHALL check rounds=0, state_in=320'h1234 pattern -> out_valid after 1 cycle, state_out unchanged; rounds=15 -> identical to rounds=12.
REQ-033 SHALL check out_ready held low 5 cycles in DONE -> state_out and out_valid stable, in_ready low, then handshake -> in_ready high next cycle.
REQ-034 SHALL check rst asserted in cycle 3 of a 12-round run -> outputs at reset values immediately, no out_valid, next request correct.
REQ-035 SHALL check (ASCON_PERM_ABORT_EN) abort with in_valid in cycle 4 of RUN -> IDLE next cycle, state_out=0, request not accepted until abort low.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation engine: state layout,
// round-constant table and the rotation helper used by the linear layer.
package ascon_pkg;

    // Word w of the state lives in [w]; x0 is therefore bits [63:0] of the flat vector.
    typedef logic [4:0][63:0] ascon_state_t;

    localparam int MAX_ROUNDS = 12;

    // Entry i is ((15-i)<<4)|i for round indices 0..11.
    localparam logic [11:0][7:0] ROUND_CONST = {
        8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
        8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
    };

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return (idx < 4'd12) ? ROUND_CONST[idx] : 8'h00;
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer and
// linear diffusion layer. With en low the state passes through untouched.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_i,
    input  logic [3:0]   round_idx,
    input  logic         en,
    output ascon_state_t state_o
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    always_comb begin
        // Constant addition folded together with the S-box input XORs.
        a0 = state_i[0] ^ state_i[4];
        a1 = state_i[1];
        a2 = state_i[2] ^ {56'd0, round_const(round_idx)} ^ state_i[1];
        a3 = state_i[3];
        a4 = state_i[4] ^ state_i[3];

        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        c0 = b0 ^ b4;
        c1 = b1 ^ b0;
        c2 = ~b2;
        c3 = b3 ^ b2;
        c4 = b4;

        state_o = state_i;
        if (en) begin
            state_o[0] = c0 ^ rotr64(c0, 19) ^ rotr64(c0, 28);
            state_o[1] = c1 ^ rotr64(c1, 61) ^ rotr64(c1, 39);
            state_o[2] = c2 ^ rotr64(c2, 1)  ^ rotr64(c2, 6);
            state_o[3] = c3 ^ rotr64(c3, 10) ^ rotr64(c3, 17);
            state_o[4] = c4 ^ rotr64(c4, 7)  ^ rotr64(c4, 41);
        end
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative Ascon permutation engine applying UNROLL rounds per clock.
// Optional ASCON_PERM_ABORT_EN adds an abort input that cancels a running job.
module ascon_perm_engine #(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   rounds,
    input  logic [319:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] state_out,
    output logic         busy
`ifdef ASCON_PERM_ABORT_EN
    ,
    input  logic         abort
`endif
);
    import ascon_pkg::*;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and data is held while valid is high and ready is low.

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] UNROLL_W = 4'(UNROLL);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 ||
          UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
        $error("UNROLL must be one of 1, 2, 3, 4, 6, 12");
    end
    if (MAX_ROUNDS != ascon_pkg::MAX_ROUNDS) begin : g_bad_max_rounds
        $error("MAX_ROUNDS must be 12");
    end

    logic [1:0]   fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    logic [3:0]   rem_q, rem_d;
    logic [3:0]   idx_q, idx_d;

    logic         abort_w;
    logic         accept;
    logic         active;
    logic [3:0]   req_n;
    logic [3:0]   base_rem;
    logic [3:0]   base_idx;
    logic [3:0]   step;
    ascon_state_t chain [UNROLL+1];

`ifdef ASCON_PERM_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign in_ready  = (fsm_q == ST_IDLE) && !abort_w;
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q != ST_IDLE);
    assign state_out = state_q;

    // The first batch of rounds is applied to state_in on the accept edge, so a
    // job of n rounds raises out_valid ceil(n/UNROLL) cycles after it is accepted.
    always_comb begin
        req_n    = (rounds > 4'd12) ? 4'd12 : rounds;
        accept   = in_valid && in_ready;
        active   = accept || (fsm_q == ST_RUN);
        base_rem = accept ? req_n : rem_q;
        base_idx = accept ? (4'd12 - req_n) : idx_q;
        step     = (base_rem > UNROLL_W) ? UNROLL_W : base_rem;
    end

    assign chain[0] = accept ? ascon_state_t'(state_in) : state_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        ascon_round u_round (
            .state_i   (chain[g]),
            .round_idx (base_idx + 4'(g)),
            .en        (active && (4'(g) < base_rem)),
            .state_o   (chain[g+1])
        );
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        case (fsm_q)
            ST_IDLE, ST_RUN: begin
                if (active) begin
                    state_d = chain[UNROLL];
                    rem_d   = base_rem - step;
                    idx_d   = base_idx + step;
                    fsm_d   = (base_rem == step) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        if (abort_w && (fsm_q != ST_IDLE)) begin
            fsm_d   = ST_IDLE;
            state_d = '0;
            rem_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Self-checking bench for ascon_perm_engine: UNROLL=1 and UNROLL=4 instances share
// stimulus; a table-driven S-box model predicts results. Define ASCON_PERM_ABORT_EN to cover abort.
module tb_ascon_perm_engine;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [3:0]   rounds;
    logic [319:0] state_in;
    logic         out_ready;
`ifdef ASCON_PERM_ABORT_EN
    logic         abort;
`endif

    logic         in_ready1, out_valid1, busy1;
    logic [319:0] state_out1;
    logic         in_ready4, out_valid4, busy4;
    logic [319:0] state_out4;

    int n_checks = 0;
    int n_errors = 0;

    logic [319:0] exp_q1[$];
    logic [319:0] exp_q4[$];
    logic [319:0] sb_e1, sb_e4;

    ascon_perm_engine #(.UNROLL(1), .MAX_ROUNDS(12)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .rounds    (rounds),
        .state_in  (state_in),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .state_out (state_out1),
        .busy      (busy1)
`ifdef ASCON_PERM_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    ascon_perm_engine #(.UNROLL(4), .MAX_ROUNDS(12)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .rounds    (rounds),
        .state_in  (state_in),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .state_out (state_out4),
        .busy      (busy4)
`ifdef ASCON_PERM_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // golden model
    function automatic logic [63:0] ror(input logic [63:0] v, input int k);
        return (v >> k) | (v << (64 - k));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int nreq);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  o;
        logic [7:0]  rc;
        int          n;
        n = (nreq > 12) ? 12 : nreq;
        for (int w = 0; w < 5; w++) x[w] = s_in[64*w +: 64];
        for (int r = 12 - n; r < 12; r++) begin
            rc = 8'(((15 - r) << 4) | r);
            x[2][7:0] = x[2][7:0] ^ rc;
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[col];
                y[0][b] = o[4];
                y[1][b] = o[3];
                y[2][b] = o[2];
                y[3][b] = o[1];
                y[4][b] = o[0];
            end
            x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
            x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
            x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
            x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
            x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    function automatic int exp_lat(input int r, input int u);
        int n;
        n = (r > 12) ? 12 : r;
        return (n == 0) ? 1 : (n + u - 1) / u;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // scoreboard
    always @(negedge clk) begin
        if (out_valid1 && out_ready) begin
            n_checks++;
            if (exp_q1.size() == 0) begin
                n_errors++;
                $display("FAIL sb_u1_unexpected: out_valid with no expected result, got %h", state_out1);
            end else begin
                sb_e1 = exp_q1.pop_front();
                if (state_out1 !== sb_e1) begin
                    n_errors++;
                    $display("FAIL sb_u1_data: got %h expected %h", state_out1, sb_e1);
                end
            end
        end
        if (out_valid4 && out_ready) begin
            n_checks++;
            if (exp_q4.size() == 0) begin
                n_errors++;
                $display("FAIL sb_u4_unexpected: out_valid with no expected result, got %h", state_out4);
            end else begin
                sb_e4 = exp_q4.pop_front();
                if (state_out4 !== sb_e4) begin
                    n_errors++;
                    $display("FAIL sb_u4_data: got %h expected %h", state_out4, sb_e4);
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [3:0] r, input logic [319:0] s, input bit push1, input bit push4);
        logic [319:0] e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        rounds   = r;
        state_in = s;
        e = model_perm(s, int'(r));
        if (push1) exp_q1.push_back(e);
        if (push4) exp_q4.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat1, output int lat4);
        lat1 = 0;
        lat4 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (lat1 == 0 && out_valid1) lat1 = c;
            if (lat4 == 0 && out_valid4) lat4 = c;
            if (lat1 != 0 && lat4 != 0) break;
        end
    endtask

    // tests
    task automatic test_reset();
        #1;
        n_checks++;
        if ({in_ready1, out_valid1, busy1} !== 3'b100 || state_out1 !== 320'd0) begin
            n_errors++;
            $display("FAIL reset_u1: got rdy/vld/busy %b state %h expected 100 and 0",
                     {in_ready1, out_valid1, busy1}, state_out1);
        end
        n_checks++;
        if ({in_ready4, out_valid4, busy4} !== 3'b100 || state_out4 !== 320'd0) begin
            n_errors++;
            $display("FAIL reset_u4: got rdy/vld/busy %b state %h expected 100 and 0",
                     {in_ready4, out_valid4, busy4}, state_out4);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_p12_zero();
        int l1, l4;
        issue(4'd12, 320'd0, 1'b1, 1'b1);
        wait_done(l1, l4);
        n_checks++;
        if (l1 != 12) begin
            n_errors++;
            $display("FAIL p12_lat_u1: got %0d expected 12", l1);
        end
        n_checks++;
        if (l4 != 3) begin
            n_errors++;
            $display("FAIL p12_lat_u4: got %0d expected 3", l4);
        end
    endtask

    task automatic test_unroll4_6();
        int l1, l4;
        issue(4'd6, rand320(), 1'b1, 1'b1);
        wait_done(l1, l4);
        n_checks++;
        if (l1 != 6) begin
            n_errors++;
            $display("FAIL r6_lat_u1: got %0d expected 6", l1);
        end
        n_checks++;
        if (l4 != 2) begin
            n_errors++;
            $display("FAIL r6_lat_u4: got %0d expected 2", l4);
        end
    endtask

    task automatic test_rounds_edge();
        int l1, l4;
        logic [319:0] s;
        s = 320'h1234;
        issue(4'd0, s, 1'b1, 1'b1);
        wait_done(l1, l4);
        n_checks++;
        if (l1 != 1 || l4 != 1) begin
            n_errors++;
            $display("FAIL r0_lat: got %0d/%0d expected 1/1", l1, l4);
        end
        s = rand320();
        issue(4'd12, s, 1'b1, 1'b1);
        wait_done(l1, l4);
        issue(4'd15, s, 1'b1, 1'b1);
        wait_done(l1, l4);
        n_checks++;
        if (l1 != 12 || l4 != 3) begin
            n_errors++;
            $display("FAIL r15_lat: got %0d/%0d expected 12/3", l1, l4);
        end
    endtask

    task automatic test_random();
        int l1, l4, r;
        for (int t = 0; t < 6; t++) begin
            r = $urandom_range(0, 15);
            issue(4'(r), rand320(), 1'b1, 1'b1);
            wait_done(l1, l4);
            n_checks++;
            if (l1 != exp_lat(r, 1) || l4 != exp_lat(r, 4)) begin
                n_errors++;
                $display("FAIL rand_lat r=%0d: got %0d/%0d expected %0d/%0d",
                         r, l1, l4, exp_lat(r, 1), exp_lat(r, 4));
            end
        end
    endtask

    task automatic test_stall();
        int l1, l4;
        logic [319:0] s, e;
        s = rand320();
        e = model_perm(s, 3);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(4'd3, s, 1'b1, 1'b1);
        wait_done(l1, l4);
        n_checks++;
        if (l1 != 3 || l4 != 1) begin
            n_errors++;
            $display("FAIL stall_lat: got %0d/%0d expected 3/1", l1, l4);
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (!out_valid1 || !out_valid4 || in_ready1 || in_ready4 || !busy1 || !busy4 ||
                state_out1 !== e || state_out4 !== e) begin
                n_errors++;
                $display("FAIL stall_hold c=%0d: got vld %b%b rdy %b%b busy %b%b u1 %h u4 %h expected vld 11 rdy 00 busy 11 data %h",
                         c, out_valid1, out_valid4, in_ready1, in_ready4, busy1, busy4, state_out1, state_out4, e);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (!in_ready1 || !in_ready4 || out_valid1 || out_valid4) begin
            n_errors++;
            $display("FAIL stall_release: got rdy %b%b vld %b%b expected rdy 11 vld 00",
                     in_ready1, in_ready4, out_valid1, out_valid4);
        end
    endtask

    task automatic test_reset_mid_run();
        int l1, l4, seen;
        issue(4'd12, rand320(), 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4} !== 6'b100100 ||
            state_out1 !== 320'd0 || state_out4 !== 320'd0) begin
            n_errors++;
            $display("FAIL midrun_reset: got rdy/vld/busy %b%b%b %b%b%b u1 %h u4 %h expected 100 100 and 0",
                     in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4, state_out1, state_out4);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid1 || out_valid4) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL midrun_no_output: got %0d out_valid cycles expected 0", seen);
        end
        issue(4'd7, rand320(), 1'b1, 1'b1);
        wait_done(l1, l4);
        n_checks++;
        if (l1 != 7 || l4 != 2) begin
            n_errors++;
            $display("FAIL midrun_next_lat: got %0d/%0d expected 7/2", l1, l4);
        end
    endtask

`ifdef ASCON_PERM_ABORT_EN
    task automatic test_abort();
        int l1, l4;
        logic [319:0] s2, e2;
        issue(4'd12, rand320(), 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        s2 = rand320();
        e2 = model_perm(s2, 5);
        @(posedge clk);
        #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        rounds   = 4'd5;
        state_in = s2;
        @(negedge clk);
        n_checks++;
        if (in_ready1 || in_ready4) begin
            n_errors++;
            $display("FAIL abort_rdy: got %b%b expected 00", in_ready1, in_ready4);
        end
        @(negedge clk);
        n_checks++;
        if (busy1 || out_valid1 || in_ready1 || state_out1 !== 320'd0) begin
            n_errors++;
            $display("FAIL abort_idle: got busy %b vld %b rdy %b state %h expected 0 0 0 and 0",
                     busy1, out_valid1, in_ready1, state_out1);
        end
        @(negedge clk);
        n_checks++;
        if (busy1 || busy4) begin
            n_errors++;
            $display("FAIL abort_hold: got busy %b%b expected 00", busy1, busy4);
        end
        exp_q1.push_back(e2);
        exp_q4.push_back(e2);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(l1, l4);
        n_checks++;
        if (l1 != 5 || l4 != 2) begin
            n_errors++;
            $display("FAIL abort_next_lat: got %0d/%0d expected 5/2", l1, l4);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        rounds    = 4'd0;
        state_in  = '0;
        out_ready = 1'b1;
`ifdef ASCON_PERM_ABORT_EN
        abort     = 1'b0;
`endif
        test_reset();
        test_p12_zero();
        test_unroll4_6();
        test_rounds_edge();
        test_random();
        test_stall();
        test_reset_mid_run();
`ifdef ASCON_PERM_ABORT_EN
        test_abort();
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q1.size() != 0 || exp_q4.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d/%0d pending results expected 0/0", exp_q1.size(), exp_q4.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
